// File: rtl/noc_out_port_alloc_if.sv
// Handshake bundle between the input-buffer request logic, the output-port
// allocator and the crossbar select of one router output.
// The master side is the requester/downstream logic and the slave side is the allocator.
interface noc_out_port_alloc_if #(
    parameter int NPORTS = 5
);
    logic [NPORTS-1:0] req_i;
    logic [NPORTS-1:0] mask_i;
    logic              flit_valid_i;
    logic              credit_ret_i;
    logic [NPORTS-1:0] grant_o;
    logic [2:0]        grant_idx_o;
    logic              send_o;
    logic              locked_o;
    logic [3:0]        credit_cnt_o;
    logic              credit_err_o;
    logic              abort_o;

    modport master (
        output req_i, mask_i, flit_valid_i, credit_ret_i,
        input  grant_o, grant_idx_o, send_o, locked_o,
               credit_cnt_o, credit_err_o, abort_o
    );

    modport slave (
        input  req_i, mask_i, flit_valid_i, credit_ret_i,
        output grant_o, grant_idx_o, send_o, locked_o,
               credit_cnt_o, credit_err_o, abort_o
    );
endinterface

// File: rtl/noc_out_port_alloc.sv
// Output-port allocator for one output of a 5-port mesh router.
// It picks one requesting input round-robin and holds that grant for a whole packet.
// Each flit transfer is gated on downstream credits.
// Optional feature macro: LOCK_TIMEOUT_EN. When it is defined, a lock that makes
// no progress for TIMEOUT cycles is released and abort_o pulses.
module noc_out_port_alloc #(
    parameter int NPORTS        = 5,
    parameter int FLITS_PER_PKT = 5,
    parameter int CREDITS       = 4,
    parameter int TIMEOUT       = 64
) (
    input logic                clk,
    input logic                rst,
    noc_out_port_alloc_if.slave bus
);

    typedef enum logic {IDLE, LOCKED} state_t;

    localparam logic [2:0] IDX_NONE = 3'b111;

    // Parameter sanity: the index encoding reserves 3'b111 for "idle".
    if (NPORTS < 1 || NPORTS > 7 || FLITS_PER_PKT < 2 || FLITS_PER_PKT > 15 ||
        CREDITS < 1 || CREDITS > 15 || TIMEOUT < 1) begin : g_bad_params
        $error("noc_out_port_alloc: parameter out of range");
    end

    state_t            state;
    logic [NPORTS-1:0] grant_q;
    logic [2:0]        grant_idx_q;
    logic              locked_q;
    logic [2:0]        rr_ptr;
    logic [3:0]        flit_cnt;
    logic [3:0]        credit_cnt;
    logic              credit_err_q;
    logic              send;
    logic [3:0]        pick;
    logic [2:0]        next_ptr;
    logic              abort_q;

    // Search from ptr upward, wrapping; the result is {found, index}.
    function automatic logic [3:0] rr_pick(input logic [NPORTS-1:0] elig,
                                           input logic [2:0] ptr);
        logic [3:0] result;
        int         idx;
        result = 4'b0000;
        for (int k = 0; k < NPORTS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NPORTS) idx = idx - NPORTS;
            if (!result[3] && elig[idx]) result = {1'b1, 3'(idx)};
        end
        return result;
    endfunction

    assign pick     = rr_pick(bus.req_i & ~bus.mask_i, rr_ptr);
    assign send     = locked_q & bus.flit_valid_i & (credit_cnt != 4'd0);
    assign next_ptr = (grant_idx_q == 3'(NPORTS - 1)) ? 3'd0 : grant_idx_q + 3'd1;

`ifdef LOCK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;
`endif

    // Arbitration FSM: grant in IDLE, hold for a packet in LOCKED, then release and advance the pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant_q     <= '0;
            grant_idx_q <= IDX_NONE;
            locked_q    <= 1'b0;
            rr_ptr      <= 3'd0;
            flit_cnt    <= 4'd0;
            abort_q     <= 1'b0;
`ifdef LOCK_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
        end else begin
            abort_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick[3]) begin
                        state       <= LOCKED;
                        locked_q    <= 1'b1;
                        grant_q     <= NPORTS'(1) << pick[2:0];
                        grant_idx_q <= pick[2:0];
                        flit_cnt    <= 4'd0;
`ifdef LOCK_TIMEOUT_EN
                        tmo_cnt     <= '0;
`endif
                    end
                end
                LOCKED: begin
                    if (send) begin
`ifdef LOCK_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                        if (flit_cnt == 4'(FLITS_PER_PKT - 1)) begin
                            state       <= IDLE;
                            locked_q    <= 1'b0;
                            grant_q     <= '0;
                            grant_idx_q <= IDX_NONE;
                            flit_cnt    <= 4'd0;
                            rr_ptr      <= next_ptr;
                        end else begin
                            flit_cnt <= flit_cnt + 4'd1;
                        end
                    end
`ifdef LOCK_TIMEOUT_EN
                    else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        state       <= IDLE;
                        locked_q    <= 1'b0;
                        grant_q     <= '0;
                        grant_idx_q <= IDX_NONE;
                        flit_cnt    <= 4'd0;
                        rr_ptr      <= next_ptr;
                        tmo_cnt     <= '0;
                        abort_q     <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Downstream credit counter: it runs in every state and flags a return that would overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_cnt   <= 4'(CREDITS);
            credit_err_q <= 1'b0;
        end else begin
            credit_err_q <= 1'b0;
            if (bus.credit_ret_i && !send) begin
                if (credit_cnt == 4'(CREDITS)) credit_err_q <= 1'b1;
                else                           credit_cnt   <= credit_cnt + 4'd1;
            end else if (!bus.credit_ret_i && send) begin
                credit_cnt <= credit_cnt - 4'd1;
            end
        end
    end

    assign bus.grant_o      = grant_q;
    assign bus.grant_idx_o  = grant_idx_q;
    assign bus.send_o       = send;
    assign bus.locked_o     = locked_q;
    assign bus.credit_cnt_o = credit_cnt;
    assign bus.credit_err_o = credit_err_q;
    assign bus.abort_o      = abort_q;

endmodule

// File: tb/tb_noc_out_port_alloc.sv
// Self-checking bench for noc_out_port_alloc.
// A packet-level model predicts every output on every cycle.
// Directed scenarios pin literal values: reset, a single packet, round-robin order,
// credit stall, credit corners, and reset in mid-packet.
// These are followed by a randomized run.
module tb_noc_out_port_alloc;
    localparam int NPORTS  = 5;
    localparam int FLITS   = 5;
    localparam int CREDITS = 4;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NPORTS-1:0] req = '0;
    logic [NPORTS-1:0] mask = '0;
    logic fv = 1'b0;
    logic cr = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;
    logic last_send;

    // Model state: packet owner, flits sent, credits held and the round-robin pointer.
    bit m_locked;
    int m_owner, m_ptr, m_flits, m_credits, m_idle;
    bit m_err, m_abort;

    int order_q[$];
    bit rec_en = 1'b0;
    logic [2:0] prev_idx = 3'b111;

    always #5 clk = ~clk;

    noc_out_port_alloc_if #(.NPORTS(NPORTS)) bus ();

    assign bus.req_i        = req;
    assign bus.mask_i       = mask;
    assign bus.flit_valid_i = fv;
    assign bus.credit_ret_i = cr;

    noc_out_port_alloc #(
        .NPORTS(NPORTS), .FLITS_PER_PKT(FLITS), .CREDITS(CREDITS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model step: advance one clock using the inputs that were present at this edge.
    always @(posedge clk) begin
        bit snd;
        logic [NPORTS-1:0] elig;
        snd = 1'b0;
        elig = '0;
        if (rst) begin
            m_locked = 0; m_owner = 0; m_ptr = 0; m_flits = 0;
            m_credits = CREDITS; m_idle = 0; m_err = 0; m_abort = 0;
        end else begin
            snd = m_locked && fv && (m_credits != 0);
            m_err = 0;
            m_abort = 0;
            if (cr && !snd) begin
                if (m_credits == CREDITS) m_err = 1;
                else m_credits = m_credits + 1;
            end else if (!cr && snd) begin
                m_credits = m_credits - 1;
            end
            if (!m_locked) begin
                elig = req & ~mask;
                for (int k = 0; k < NPORTS; k++) begin
                    if (!m_locked && elig[(m_ptr + k) % NPORTS]) begin
                        m_owner  = (m_ptr + k) % NPORTS;
                        m_locked = 1;
                        m_flits  = 0;
                        m_idle   = 0;
                    end
                end
            end else if (snd) begin
                m_idle  = 0;
                m_flits = m_flits + 1;
                if (m_flits == FLITS) begin
                    m_flits  = 0;
                    m_locked = 0;
                    m_ptr    = (m_owner + 1) % NPORTS;
                end
            end else begin
`ifdef LOCK_TIMEOUT_EN
                m_idle = m_idle + 1;
                if (m_idle == TIMEOUT) begin
                    m_idle   = 0;
                    m_flits  = 0;
                    m_locked = 0;
                    m_abort  = 1;
                    m_ptr    = (m_owner + 1) % NPORTS;
                end
`endif
            end
        end
    end

    // Compare every DUT output against the model at mid-cycle.
    always @(negedge clk) begin
        if (check_en) begin
            check_output("grant", 32'(bus.grant_o), m_locked ? (32'd1 << m_owner) : 32'd0);
            check_output("grant_idx", 32'(bus.grant_idx_o), m_locked ? 32'(m_owner) : 32'd7);
            check_output("locked", 32'(bus.locked_o), 32'(m_locked));
            check_output("send", 32'(bus.send_o), 32'(m_locked && fv && (m_credits != 0)));
            check_output("credit_cnt", 32'(bus.credit_cnt_o), 32'(m_credits));
            check_output("credit_err", 32'(bus.credit_err_o), 32'(m_err));
            check_output("abort", 32'(bus.abort_o), 32'(m_abort));
        end
    end

    // Record the order of new grants for the round-robin scenarios.
    always @(negedge clk) begin
        if (rec_en && prev_idx == 3'b111 && bus.grant_idx_o != 3'b111)
            order_q.push_back(int'(bus.grant_idx_o));
        prev_idx = bus.grant_idx_o;
    end

    // Drive one cycle of inputs, capture send_o mid-cycle, and return just after the next edge.
    task automatic apply_stimulus(input logic r, input logic [NPORTS-1:0] rq,
                                  input logic [NPORTS-1:0] mk, input logic v, input logic c);
        rst  = r;
        req  = rq;
        mask = mk;
        fv   = v;
        cr   = c;
        @(negedge clk);
        last_send = bus.send_o;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        apply_stimulus(1'b1, '0, '0, 1'b0, 1'b0);
        check_en = 1'b1;
        apply_stimulus(1'b1, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic check_idle_values(input string tag);
        check_output({tag, "_idx"}, 32'(bus.grant_idx_o), 32'd7);
        check_output({tag, "_grant"}, 32'(bus.grant_o), 32'd0);
        check_output({tag, "_credits"}, 32'(bus.credit_cnt_o), 32'd4);
        check_output({tag, "_locked"}, 32'(bus.locked_o), 32'd0);
    endtask

    initial begin
        int sends;
        int exp_rr[6];
        int exp_mk[5];
        exp_rr = '{0, 1, 2, 3, 4, 0};
        exp_mk = '{0, 2, 3, 4, 0};

        // Reset values.
        do_reset();
        check_idle_values("t1");

        // Single packet from input 2.
        apply_stimulus(1'b0, 5'b00100, '0, 1'b1, 1'b1);
        check_output("t2_grant_idx", 32'(bus.grant_idx_o), 32'd2);
        sends = 0;
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b0, 5'b00100, '0, 1'b1, 1'b1);
            if (last_send) sends++;
        end
        check_output("t2_sends", 32'(sends), 32'd5);
        check_output("t2_release_idx", 32'(bus.grant_idx_o), 32'd7);
        apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0);

        // Round-robin with all inputs requesting.
        do_reset();
        order_q.delete();
        rec_en = 1'b1;
        for (int i = 0; i < 36; i++) apply_stimulus(1'b0, 5'b11111, '0, 1'b1, 1'b1);
        rec_en = 1'b0;
        check_output("t3_count", 32'(order_q.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            if (i < order_q.size()) check_output("t3_order", 32'(order_q[i]), 32'(exp_rr[i]));

        // Round-robin with input 1 masked.
        do_reset();
        order_q.delete();
        rec_en = 1'b1;
        for (int i = 0; i < 30; i++) apply_stimulus(1'b0, 5'b11111, 5'b00010, 1'b1, 1'b1);
        rec_en = 1'b0;
        check_output("t3m_count", 32'(order_q.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < order_q.size()) check_output("t3m_order", 32'(order_q[i]), 32'(exp_mk[i]));

        // Credit stall: four flits drain the credits, then one return releases the fifth.
        do_reset();
        apply_stimulus(1'b0, 5'b00001, '0, 1'b1, 1'b0);
        sends = 0;
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(1'b0, 5'b00001, '0, 1'b1, 1'b0);
            if (last_send) sends++;
        end
        check_output("t4_sends", 32'(sends), 32'd4);
        check_output("t4_stall_send", 32'(last_send), 32'd0);
        check_output("t4_credits", 32'(bus.credit_cnt_o), 32'd0);
        check_output("t4_locked", 32'(bus.locked_o), 32'd1);
        apply_stimulus(1'b0, 5'b00001, '0, 1'b1, 1'b1);
        check_output("t4_ret_credits", 32'(bus.credit_cnt_o), 32'd1);
        apply_stimulus(1'b0, '0, '0, 1'b1, 1'b0);
        check_output("t4_fifth_send", 32'(last_send), 32'd1);
        check_output("t4_release_idx", 32'(bus.grant_idx_o), 32'd7);
        check_output("t4_end_credits", 32'(bus.credit_cnt_o), 32'd0);

        // Credit corners: overflow in IDLE, then simultaneous return and send.
        do_reset();
        apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1);
        check_output("t5_err", 32'(bus.credit_err_o), 32'd1);
        check_output("t5_err_cnt", 32'(bus.credit_cnt_o), 32'd4);
        apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0);
        check_output("t5_err_clear", 32'(bus.credit_err_o), 32'd0);
        apply_stimulus(1'b0, 5'b00001, '0, 1'b1, 1'b0);
        apply_stimulus(1'b0, '0, '0, 1'b1, 1'b0);
        check_output("t5_send_cnt", 32'(bus.credit_cnt_o), 32'd3);
        apply_stimulus(1'b0, '0, '0, 1'b1, 1'b1);
        check_output("t5_both_send", 32'(last_send), 32'd1);
        check_output("t5_both_cnt", 32'(bus.credit_cnt_o), 32'd3);

        // Reset in mid-packet drops the lock at once.
        do_reset();
        apply_stimulus(1'b0, 5'b01000, '0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 5'b01000, '0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 5'b01000, '0, 1'b1, 1'b0);
        apply_stimulus(1'b1, 5'b01000, '0, 1'b1, 1'b0);
        check_idle_values("t6_rst");
        apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0);

`ifdef LOCK_TIMEOUT_EN
        // Timeout: a lock with no flits is released and the next grant goes to winner+1.
        do_reset();
        apply_stimulus(1'b0, 5'b00010, '0, 1'b0, 1'b0);
        for (int i = 0; i < TIMEOUT; i++) apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0);
        check_output("t6_abort", 32'(bus.abort_o), 32'd1);
        check_output("t6_abort_idx", 32'(bus.grant_idx_o), 32'd7);
        apply_stimulus(1'b0, 5'b11111, '0, 1'b0, 1'b0);
        check_output("t6_next_grant", 32'(bus.grant_idx_o), 32'd2);
`endif

        // Randomized traffic against the model, with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            apply_stimulus(($urandom_range(0, 199) == 0),
                           NPORTS'($urandom_range(0, 31)),
                           ($urandom_range(0, 3) == 0) ? NPORTS'($urandom_range(0, 31)) : '0,
                           ($urandom_range(0, 9) < 7),
                           ($urandom_range(0, 2) == 0));
        end

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
